norm_denorm_ctrl: RTL and testbench

Controller plus shift datapath that drives the 5-bit up/down counter (counter_5bit) through its cntU/cntD/rst5 inputs and consumes its down_done flag. It normalizes an operand by shifting left until MSB=1, with the counter recording the shift amount. It then hands the normalized word to a downstream processing stage. When the processed word returns, it de-normalizes that word by shifting right while counting the counter back down to zero.

---
 rtl/norm_denorm_pkg.sv | 21 ++
 rtl/counter_5bit.sv | 51 +++++
 rtl/norm_shift_reg.sv | 51 +++++
 rtl/norm_denorm_ctrl.sv | 167 ++++++++++++++++
 tb/tb_norm_denorm_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/norm_denorm_pkg.sv
// -----------------------------------------------------------------------------
// norm_denorm_pkg
// Shared types and constants for the normalize / de-normalize controller.
//   state_e    : controller state, binary encoded
//   CNT_W      : width of the external shift-amount counter
//   MAX_DATA_W : widest operand whose shift count still fits in CNT_W bits
// -----------------------------------------------------------------------------
package norm_denorm_pkg;

    localparam int CNT_W      = 5;
    localparam int MAX_DATA_W = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        NORM      = 3'd1,
        WAIT_PROC = 3'd2,
        DENORM    = 3'd3,
        DONE      = 3'd4
    } state_e;

endpackage

// File: rtl/counter_5bit.sv
// -----------------------------------------------------------------------------
// counter_5bit
// Up/down counter that records the normalization shift amount.
//   clk, rst   : clock, synchronous active-high reset
//   rst5       : synchronous clear (highest priority after rst)
//   cntU, cntD : count up / count down by one
//   count      : current value
//   down_done  : high while count is zero
// -----------------------------------------------------------------------------
module counter_5bit
    import norm_denorm_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             rst5,
    input  logic             cntU,
    input  logic             cntD,
    output logic [CNT_W-1:0] count,
    output logic             down_done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear beats up, up beats down.
    always_comb begin
        count_d = count_q;
        if (rst5) begin
            count_d = {CNT_W{1'b0}};
        end else if (cntU) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (cntD) begin
            count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count     = count_q;
    assign down_done = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/norm_shift_reg.sv
// -----------------------------------------------------------------------------
// norm_shift_reg
// DATA_W working register for the normalize / de-normalize datapath.
//   clk, rst   : clock, synchronous active-high reset (clears to zero)
//   load_i     : load load_val_i (highest priority)
//   load_val_i : value to load
//   shl_i      : logical shift left by one, zero fill
//   shr_i      : logical shift right by one, zero fill
//   q_o        : register contents
// -----------------------------------------------------------------------------
module norm_shift_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_val_i,
    input  logic              shl_i,
    input  logic              shr_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] sh_q;
    logic [DATA_W-1:0] sh_d;

    // Next value: load, else shift left, else shift right, else hold.
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = load_val_i;
        end else if (shl_i) begin
            sh_d = {sh_q[DATA_W-2:0], 1'b0};
        end else if (shr_i) begin
            sh_d = {1'b0, sh_q[DATA_W-1:1]};
        end else begin
            sh_d = sh_q;
        end
    end

    // Working register.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q <= {DATA_W{1'b0}};
        end else begin
            sh_q <= sh_d;
        end
    end

    assign q_o = sh_q;

endmodule

// File: rtl/norm_denorm_ctrl.sv
// -----------------------------------------------------------------------------
// norm_denorm_ctrl
// Normalizes an operand (shift left until MSB=1) while an external counter
// records the shift amount, hands the normalized word downstream, then
// de-normalizes the returned word by shifting right while counting back to 0.
//   clk, rst   : clock, synchronous active-high reset (aborts any operation)
//   start      : begin operation, sampled in IDLE only, with data_in
//   norm_out   : normalized word, valid while norm_valid=1
//   norm_valid : high throughout WAIT_PROC
//   proc_in    : processed word, taken when proc_valid=1 in WAIT_PROC
//   cnt_clr    : counter clear   (combinational)
//   cnt_up     : counter up      (combinational)
//   cnt_dn     : counter down    (combinational)
//   down_done  : counter is zero, looked at in DENORM only
//   data_out   : de-normalized result, held until the next result
//   out_valid  : one-cycle pulse in DONE
//   busy       : high in any state other than IDLE
// -----------------------------------------------------------------------------
module norm_denorm_ctrl
    import norm_denorm_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] norm_out,
    output logic              norm_valid,
    input  logic [DATA_W-1:0] proc_in,
    input  logic              proc_valid,
    output logic              cnt_clr,
    output logic              cnt_up,
    output logic              cnt_dn,
    input  logic              down_done,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    output logic              busy
);

    // At most DATA_W-1 shifts must fit the counter without wrapping.
    if ((DATA_W < 2) || (DATA_W > MAX_DATA_W)) begin : g_bad_width
        $error("norm_denorm_ctrl: DATA_W out of range 2..32");
    end

    state_e            state_q;
    state_e            state_d;
    logic [DATA_W-1:0] data_out_q;
    logic [DATA_W-1:0] data_out_d;
    logic              norm_valid_q;
    logic              out_valid_q;
    logic              busy_q;

    logic [DATA_W-1:0] sh_s;
    logic              load_s;
    logic [DATA_W-1:0] load_val_s;
    logic              shl_s;
    logic              shr_s;
    logic              clr_s;
    logic              up_s;
    logic              dn_s;

    norm_shift_reg #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .load_i     (load_s),
        .load_val_i (load_val_s),
        .shl_i      (shl_s),
        .shr_i      (shr_s),
        .q_o        (sh_s)
    );

    // Next state, datapath controls and counter strobes.
    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        load_s     = 1'b0;
        load_val_s = data_in;
        shl_s      = 1'b0;
        shr_s      = 1'b0;
        clr_s      = 1'b0;
        up_s       = 1'b0;
        dn_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    clr_s = 1'b1;
                    if (data_in == {DATA_W{1'b0}}) begin
                        // Nothing to normalize: zero result, skip downstream.
                        data_out_d = {DATA_W{1'b0}};
                        state_d    = DONE;
                    end else begin
                        load_s     = 1'b1;
                        load_val_s = data_in;
                        state_d    = NORM;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            NORM: begin
                if (sh_s[DATA_W-1]) begin
                    state_d = WAIT_PROC;
                end else begin
                    shl_s = 1'b1;
                    up_s  = 1'b1;
                end
            end
            WAIT_PROC: begin
                if (proc_valid) begin
                    load_s     = 1'b1;
                    load_val_s = proc_in;
                    state_d    = DENORM;
                end else begin
                    state_d = WAIT_PROC;
                end
            end
            DENORM: begin
                // The counter holds the remaining right shifts.
                if (down_done) begin
                    data_out_d = sh_s;
                    state_d    = DONE;
                end else begin
                    shr_s = 1'b1;
                    dn_s  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            data_out_q   <= {DATA_W{1'b0}};
            norm_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_out_q   <= data_out_d;
            norm_valid_q <= (state_d == WAIT_PROC);
            out_valid_q  <= (state_d == DONE);
            busy_q       <= (state_d != IDLE);
        end
    end

    // Strobes are silenced during reset; the counter is reset by rst itself.
    assign cnt_clr    = clr_s & ~rst;
    assign cnt_up     = up_s  & ~rst;
    assign cnt_dn     = dn_s  & ~rst;

    assign norm_out   = sh_s;
    assign norm_valid = norm_valid_q;
    assign data_out   = data_out_q;
    assign out_valid  = out_valid_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_norm_denorm_ctrl.sv
module tb_norm_denorm_ctrl;

    localparam int W = 16;

    localparam int P_IDLE   = 0;
    localparam int P_NORM   = 1;
    localparam int P_WAIT   = 2;
    localparam int P_DENORM = 3;
    localparam int P_DONE   = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] data_in;
    logic [W-1:0] proc_in;
    logic         proc_valid;
    logic [W-1:0] norm_out;
    logic         norm_valid;
    logic         cnt_clr, cnt_up, cnt_dn;
    logic         down_done;
    logic [W-1:0] data_out;
    logic         out_valid;
    logic         busy;
    logic [4:0]   cnt_val;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;

    norm_denorm_ctrl #(.DATA_W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .data_in    (data_in),
        .norm_out   (norm_out),
        .norm_valid (norm_valid),
        .proc_in    (proc_in),
        .proc_valid (proc_valid),
        .cnt_clr    (cnt_clr),
        .cnt_up     (cnt_up),
        .cnt_dn     (cnt_dn),
        .down_done  (down_done),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .busy       (busy)
    );

    counter_5bit u_cnt (
        .clk       (clk),
        .rst       (rst),
        .rst5      (cnt_clr),
        .cntU      (cnt_up),
        .cntD      (cnt_dn),
        .count     (cnt_val),
        .down_done (down_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int clz(input logic [W-1:0] v);
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i]) return W - 1 - i;
        end
        return W;
    endfunction

    // ---------------- behavioural model (transaction level) ----------------
    int           m_phase = P_IDLE;
    int           m_lz    = 0;
    int           m_steps = 0;
    int           m_cnt   = 0;
    logic [W-1:0] m_norm_word = '0;
    logic [W-1:0] m_proc_word = '0;
    logic [W-1:0] m_result    = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_phase  <= P_IDLE;
            m_result <= '0;
            m_cnt    <= 0;
        end else begin
            case (m_phase)
                P_IDLE: if (start) begin
                    m_cnt <= 0;
                    if (data_in == '0) begin
                        m_result <= '0;
                        m_phase  <= P_DONE;
                    end else begin
                        m_lz        <= clz(data_in);
                        m_norm_word <= data_in << clz(data_in);
                        m_steps     <= 0;
                        m_phase     <= P_NORM;
                    end
                end
                P_NORM: if (m_steps == m_lz) m_phase <= P_WAIT;
                        else begin m_steps <= m_steps + 1; m_cnt <= m_cnt + 1; end
                P_WAIT: if (proc_valid) begin
                    m_proc_word <= proc_in;
                    m_steps     <= 0;
                    m_phase     <= P_DENORM;
                end
                P_DENORM: if (m_steps == m_lz) begin
                    m_result <= m_proc_word >> m_lz;
                    m_phase  <= P_DONE;
                end else begin
                    m_steps <= m_steps + 1;
                    m_cnt   <= m_cnt - 1;
                end
                default: m_phase <= P_IDLE;
            endcase
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy",       busy,       m_phase != P_IDLE);
            check("norm_valid", norm_valid, m_phase == P_WAIT);
            check("out_valid",  out_valid,  m_phase == P_DONE);
            check("data_out",   data_out,   m_result);
            check("counter",    cnt_val,    32'(m_cnt));
            check("cnt_clr",    cnt_clr,    (m_phase == P_IDLE) && start && !rst);
            check("cnt_up",     cnt_up,     (m_phase == P_NORM) && (m_steps < m_lz) && !rst);
            check("cnt_dn",     cnt_dn,     (m_phase == P_DENORM) && (m_steps < m_lz) && !rst);
            if (m_phase == P_WAIT) check("norm_out", norm_out, m_norm_word);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic run_txn(input logic [W-1:0] din, input logic [W-1:0] pin,
                           input int wait_cyc, input bit noise, input bit lit,
                           input logic [W-1:0] e_norm, input int e_cnt,
                           input logic [W-1:0] e_out);
        start   = 1'b1;
        data_in = din;
        step();
        start   = 1'b0;
        data_in = W'($urandom);
        for (int k = 0; k < 100; k++) begin
            if (norm_valid || out_valid) break;
            if (noise) begin start = 1'($urandom); proc_valid = 1'($urandom); proc_in = W'($urandom); end
            step();
        end
        start = 1'b0;
        proc_valid = 1'b0;
        if (!out_valid) begin
            check("reach_norm_valid", norm_valid, 1'b1);
            if (lit) begin
                check("lit_norm_out", norm_out, e_norm);
                check("lit_norm_cnt", cnt_val, 32'(e_cnt));
            end
            for (int k = 0; k < wait_cyc; k++) begin
                start = 1'($urandom);
                step();
            end
            start      = 1'b0;
            proc_valid = 1'b1;
            proc_in    = pin;
            step();
            proc_valid = 1'b0;
            proc_in    = W'($urandom);
            for (int k = 0; k < 100; k++) begin
                if (out_valid) break;
                if (noise) begin start = 1'($urandom); proc_valid = 1'($urandom); end
                step();
            end
            start = 1'b0;
            proc_valid = 1'b0;
        end
        check("reach_out_valid", out_valid, 1'b1);
        if (lit) begin
            check("lit_data_out", data_out, e_out);
            check("lit_cnt_end", cnt_val, 32'd0);
        end
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; proc_valid = 1'b0; data_in = '0; proc_in = '0;
        repeat (3) step();
        chk_en = 1'b1;
        check("rst_busy", busy, 1'b0);
        check("rst_data_out", data_out, 16'h0000);
        check("rst_counter", cnt_val, 5'd0);
        rst = 1'b0;
        step();

        run_txn(16'h0100, 16'hC000, 2, 1'b0, 1'b1, 16'h8000, 7,  16'h0180);
        run_txn(16'h8001, 16'h1234, 0, 1'b0, 1'b1, 16'h8001, 0,  16'h1234);
        run_txn(16'h0000, 16'h5555, 0, 1'b0, 1'b1, 16'h0000, 0,  16'h0000);
        run_txn(16'h0001, 16'hFFFF, 1, 1'b0, 1'b1, 16'h8000, 15, 16'h0001);
        run_txn(16'h0100, 16'hC000, 3, 1'b1, 1'b1, 16'h8000, 7,  16'h0180);

        // Stray proc_valid while idle must be ignored.
        for (int k = 0; k < 4; k++) begin
            proc_valid = 1'($urandom); proc_in = W'($urandom);
            step();
        end
        proc_valid = 1'b0;

        // Reset in DENORM with counter=4 aborts the operation.
        start = 1'b1; data_in = 16'h0800;
        step();
        start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (norm_valid) break;
            step();
        end
        check("rst_pre_norm_valid", norm_valid, 1'b1);
        proc_valid = 1'b1; proc_in = 16'hABCD;
        step();
        proc_valid = 1'b0;
        check("rst_pre_counter", cnt_val, 5'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_data_out", data_out, 16'h0000);
        check("rst_mid_counter", cnt_val, 5'd0);
        check("rst_mid_strobes", {cnt_clr, cnt_up, cnt_dn, out_valid}, 4'b0000);
        run_txn(16'h0030, 16'h8000, 1, 1'b0, 1'b1, 16'hC000, 10, 16'h0020);

        // Randomized transactions checked by the model.
        for (int t = 0; t < 40; t++) begin
            logic [W-1:0] d;
            d = W'($urandom >> $urandom_range(0, 31));
            if ($urandom_range(0, 9) == 0) d = '0;
            run_txn(d, W'($urandom), $urandom_range(0, 3), 1'($urandom), 1'b0, '0, 0, '0);
        end

        repeat (2) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
